bcd_scan_display: RTL and testbench

//  Parametrised multi-field display engine. On a load strobe it snapshots
//  NUM_FIELDS binary fields plus decimal points, then converts each field to
//  two BCD digits with a sequential shift-add-3 (double-dabble) FSM. The

---
 rtl/bcd_scan_display_if.sv | 30 +++
 rtl/bcd_scan_display.sv | 153 +++++++++++++++
 tb/tb_bcd_scan_display.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Bus bundle for bcd_scan_display: load/enable controls in, scanned digit out.
// Latency: none (wires only).  Backpressure: none; the producer watches o_busy.
// Producer side uses master, the display engine uses slave.
interface bcd_scan_display_if #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 7
);
    localparam int ND = 2 * NUM_FIELDS;
    localparam int IW = $clog2(ND);

    logic                          i_en;
    logic                          i_load;
    logic [NUM_FIELDS*FIELD_W-1:0] i_fields;
    logic [ND-1:0]                 i_dp;
    logic                          o_busy;
    logic [ND-1:0]                 o_digit_sel;
    logic [IW-1:0]                 o_digit_idx;
    logic [3:0]                    o_bcd;
    logic                          o_dp;

    modport master (
        output i_en, i_load, i_fields, i_dp,
        input  o_busy, o_digit_sel, o_digit_idx, o_bcd, o_dp
    );

    modport slave (
        input  i_en, i_load, i_fields, i_dp,
        output o_busy, o_digit_sel, o_digit_idx, o_bcd, o_dp
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Snapshots binary fields, converts each to two BCD digits, scans them onto one digit bus.
// Latency: o_busy high NUM_FIELDS*(FIELD_W+1) cycles; new digits visible once it drops.
// Backpressure: i_load is dropped while busy (no queueing); scanner holds when i_en=0.
module bcd_scan_display #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 7,
    parameter int SCAN_DIV   = 16,
    parameter bit LZ_BLANK   = 1'b0
) (
    input logic              i_clk,
    input logic              i_reset_n,
    bcd_scan_display_if.slave bus
);
    localparam int ND = 2 * NUM_FIELDS;
    localparam int IW = $clog2(ND);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(FIELD_W);
    localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int SW = NUM_FIELDS * FIELD_W;

    localparam logic [IW-1:0] IDX_LAST = IW'(ND - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(FIELD_W - 1);
    localparam logic [FW-1:0] FLD_LAST = FW'(NUM_FIELDS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  shadow_q;
    logic [ND-1:0]  shadow_dp_q;
    logic [ND-1:0]  disp_dp_q;
    logic [11:0]    scratch_q;
    logic [11:0]    adj;
    logic [CW-1:0]  bit_q;
    logic [FW-1:0]  fld_q;
    logic [3:0]     work_q [ND];
    logic [3:0]     disp_q [ND];
    logic [3:0]     pair_hi, pair_lo;
    logic           last_fld;
    logic [PW-1:0]  pre_q;
    logic [IW-1:0]  idx_q;
    logic [3:0]     bcd_raw;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_load) state_d = SHIFT;
            SHIFT:   if (bit_q == BIT_LAST) state_d = STORE;
            STORE:   state_d = last_fld ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy = (state_q != IDLE);
    end

    // ---------------- double-dabble datapath ----------------
    always_comb begin
        adj = scratch_q;
        for (int n = 0; n < 3; n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
        end
        // A non-zero hundreds nibble cannot be shown in two digits.
        pair_hi  = (scratch_q[11:8] != 4'd0) ? 4'hF : scratch_q[7:4];
        pair_lo  = (scratch_q[11:8] != 4'd0) ? 4'hF : scratch_q[3:0];
        last_fld = (fld_q == FLD_LAST);
    end

    // Fields are packed field-0-first from the MSB, so one long left shift
    // of the snapshot feeds every field's bits MSB first, in field order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            disp_dp_q   <= '0;
            scratch_q   <= '0;
            bit_q       <= '0;
            fld_q       <= '0;
            for (int d = 0; d < ND; d++) begin
                work_q[d] <= '0;
                disp_q[d] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_load) begin
                        shadow_q    <= bus.i_fields;
                        shadow_dp_q <= bus.i_dp;
                        scratch_q   <= '0;
                        bit_q       <= '0;
                        fld_q       <= '0;
                    end
                end
                SHIFT: begin
                    scratch_q <= {adj[10:0], shadow_q[SW-1]};
                    shadow_q  <= shadow_q << 1;
                    bit_q     <= bit_q + CW'(1);
                end
                STORE: begin
                    scratch_q <= '0;
                    bit_q     <= '0;
                    for (int d = 0; d < ND; d++) begin
                        if (d == 2 * int'(fld_q))     work_q[d] <= pair_hi;
                        if (d == 2 * int'(fld_q) + 1) work_q[d] <= pair_lo;
                    end
                    // Final field: publish the whole display in one edge.
                    if (last_fld) begin
                        disp_dp_q <= shadow_dp_q;
                        for (int d = 0; d < ND; d++) begin
                            if (d == 2 * int'(fld_q))          disp_q[d] <= pair_hi;
                            else if (d == 2 * int'(fld_q) + 1) disp_q[d] <= pair_lo;
                            else                               disp_q[d] <= work_q[d];
                        end
                    end else begin
                        fld_q <= fld_q + FW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- scanner ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (bus.i_en) begin
            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

    // Even digits are field MSDs; blanking only ever replaces a zero.
    always_comb begin
        bcd_raw         = disp_q[idx_q];
        bus.o_bcd       = (LZ_BLANK && !idx_q[0] && bcd_raw == 4'd0) ? 4'hA : bcd_raw;
        bus.o_digit_idx = idx_q;
        bus.o_digit_sel = bus.i_en ? (ND'(1) << idx_q) : '0;
        bus.o_dp        = bus.i_en & disp_dp_q[IDX_LAST - idx_q];
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench: reset, scan timing/enable hold, conversion vectors, ignored loads, reset abort.
module tb_bcd_scan_display;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_scan_display_if #(.NUM_FIELDS(3), .FIELD_W(7)) ifa ();
    bcd_scan_display_if #(.NUM_FIELDS(3), .FIELD_W(7)) ifb ();

    bcd_scan_display #(.NUM_FIELDS(3), .FIELD_W(7), .SCAN_DIV(16), .LZ_BLANK(1'b0)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifa));
    bcd_scan_display #(.NUM_FIELDS(3), .FIELD_W(7), .SCAN_DIV(4), .LZ_BLANK(1'b1)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifb));

    int   n_vec = 0;
    int   n_err = 0;
    logic sel_b = 1'b0;

    logic       r_busy, r_dp;
    logic [5:0] r_sel;
    logic [2:0] r_idx;
    logic [3:0] r_bcd;
    assign r_busy = sel_b ? ifb.o_busy      : ifa.o_busy;
    assign r_dp   = sel_b ? ifb.o_dp        : ifa.o_dp;
    assign r_sel  = sel_b ? ifb.o_digit_sel : ifa.o_digit_sel;
    assign r_idx  = sel_b ? ifb.o_digit_idx : ifa.o_digit_idx;
    assign r_bcd  = sel_b ? ifb.o_bcd       : ifa.o_bcd;

    typedef struct packed {
        logic        dut_b;
        logic [20:0] fields;
        logic [5:0]  dp;
        logic [23:0] dig;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic set_en(input logic v);
        if (sel_b) ifb.i_en = v; else ifa.i_en = v;
    endtask

    task automatic set_load(input logic v);
        if (sel_b) ifb.i_load = v; else ifa.i_load = v;
    endtask

    task automatic set_data(input logic [20:0] f, input logic [5:0] dp);
        if (sel_b) begin ifb.i_fields = f; ifb.i_dp = dp; end
        else       begin ifa.i_fields = f; ifa.i_dp = dp; end
    endtask

    // Load, then check o_busy cycle by cycle; disturb re-pulses i_load with
    // different data mid-conversion and in the final STORE cycle.
    task automatic convert(input logic [20:0] f, input logic [5:0] dp, input bit disturb);
        @(negedge clk);
        set_data(f, dp);
        set_load(1'b1);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            set_load(disturb && (k == 5 || k == 24));
            if (disturb) set_data({7'd11, 7'd22, 7'd33}, ~dp);
            #1;
            check($sformatf("busy[%0d]", k), 32'(r_busy), 32'(k <= 24));
        end
        set_load(1'b0);
    endtask

    task automatic read_digits(input logic [23:0] dig, input logic [5:0] dp);
        @(negedge clk);
        set_en(1'b1);
        #1;
        for (int d = 0; d < 6; d++) begin
            int n = 0;
            while (r_idx != 3'(d) && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            check($sformatf("reach_idx%0d", d), 32'(r_idx), 32'(d));
            check($sformatf("bcd_d%0d", d), 32'(r_bcd), 32'(dig[(5-d)*4 +: 4]));
            check($sformatf("sel_d%0d", d), 32'(r_sel), 32'(6'(1) << d));
            check($sformatf("dp_d%0d", d), 32'(r_dp), 32'(dp[5-d]));
        end
        @(negedge clk);
        set_en(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ec;
        int  ei;
        bit  en_t;
        logic [23:0] scan_dig;

        vecs[0] = '{1'b0, {7'd23, 7'd59, 7'd7},   6'b000000, 24'h235907};
        vecs[1] = '{1'b0, {7'd99, 7'd100, 7'd127}, 6'b010100, 24'h99FFFF};
        vecs[2] = '{1'b1, {7'd7, 7'd0, 7'd10},     6'b001000, 24'hA7A010};
        vecs[3] = '{1'b0, {7'd0, 7'd45, 7'd68},    6'b111111, 24'h004568};
        vecs[4] = '{1'b1, {7'd99, 7'd100, 7'd5},   6'b000000, 24'h99FFA5};

        ifa.i_en = 1'b0; ifa.i_load = 1'b0; ifa.i_fields = '0; ifa.i_dp = '0;
        ifb.i_en = 1'b0; ifb.i_load = 1'b0; ifb.i_fields = '0; ifb.i_dp = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy_a", 32'(ifa.o_busy), 32'd0);
        check("rst_sel_a",  32'(ifa.o_digit_sel), 32'd0);
        check("rst_bcd_a",  32'(ifa.o_bcd), 32'd0);
        check("rst_dp_a",   32'(ifa.o_dp), 32'd0);
        check("rst_idx_a",  32'(ifa.o_digit_idx), 32'd0);
        check("rst_busy_b", 32'(ifb.o_busy), 32'd0);
        check("rst_sel_b",  32'(ifb.o_digit_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scan timing on the SCAN_DIV=4 / blanking instance, with an enable gap
        sel_b = 1'b1;
        convert({7'd23, 7'd59, 7'd7}, 6'b100001, 1'b0);
        scan_dig = 24'h2359A7;
        ec = 0;
        for (int t = 0; t < 51; t++) begin
            @(negedge clk);
            en_t = !(t >= 30 && t < 37);
            set_en(en_t);
            #1;
            ei = (ec / 4) % 6;
            check($sformatf("scan_sel[%0d]", t), 32'(r_sel), en_t ? 32'(6'(1) << ei) : 32'd0);
            check($sformatf("scan_idx[%0d]", t), 32'(r_idx), 32'(ei));
            check($sformatf("scan_bcd[%0d]", t), 32'(r_bcd), 32'(scan_dig[(5-ei)*4 +: 4]));
            check($sformatf("scan_dp[%0d]", t), 32'(r_dp), 32'(en_t && (ei == 0 || ei == 5)));
            if (en_t) ec++;
        end
        @(negedge clk);
        set_en(1'b0);

        // Conversion vector table
        for (int v = 0; v < 5; v++) begin
            sel_b = vecs[v].dut_b;
            convert(vecs[v].fields, vecs[v].dp, 1'b0);
            read_digits(vecs[v].dig, vecs[v].dp);
        end

        // Loads during a conversion and in its last cycle are dropped
        sel_b = 1'b0;
        convert({7'd23, 7'd59, 7'd7}, 6'b000110, 1'b1);
        read_digits(24'h235907, 6'b000110);

        // Reset at cycle 10 of a conversion aborts it without any commit
        @(negedge clk);
        set_data({7'd99, 7'd100, 7'd127}, 6'b111111);
        set_load(1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            set_load(1'b0);
        end
        check("abort_busy_pre", 32'(r_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(r_busy), 32'd0);
        check("abort_bcd",  32'(r_bcd), 32'd0);
        check("abort_idx",  32'(r_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("abort_busy_late", 32'(r_busy), 32'd0);
        read_digits(24'h000000, 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
